// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and constants for the serial nibble adder: FSM states,
// slice width and the nibble-counter width helper.
package serial_nibble_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int NIBBLE_W = 4;

    // A single-nibble adder still needs a one-bit counter to hold index 0.
    function automatic int cnt_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/serial_nibble_adder_nibble_adder.sv
// Purely combinational 4-bit adder slice with carry-in and carry-out; the
// controller time-multiplexes operand nibbles onto a single instance.
module nibble_adder
    import serial_nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/serial_nibble_adder.sv
// Start/busy/done controller that adds two 4*NIBBLES-bit operands one nibble
// per cycle, least-significant first, through one shared 4-bit slice.
module serial_nibble_adder
    import serial_nibble_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout
);

    localparam int              W    = NIBBLE_W * NIBBLES;
    localparam int              CW   = cnt_width(NIBBLES);
    localparam logic [CW-1:0]   LAST = CW'(NIBBLES - 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  carry;
    logic [W-1:0]          a_q;
    logic [W-1:0]          b_q;
    logic [W-1:0]          res_q;
    logic [W-1:0]          res_next;
    logic [W-1:0]          a_sh;
    logic [W-1:0]          b_sh;
    logic [NIBBLE_W-1:0]   nib_s;
    logic                  nib_c;
    logic                  accept;

    // Requests are only honoured outside RUN; DONE accepts for back-to-back use.
    assign accept = start && (state != RUN);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through this block can leave a value unassigned and infer a latch.
        a_sh     = a_q >> (NIBBLE_W * int'(cnt));
        b_sh     = b_q >> (NIBBLE_W * int'(cnt));
        res_next = res_q;
        res_next[NIBBLE_W*int'(cnt) +: NIBBLE_W] = nib_s;
    end

    nibble_adder u_slice (
        .x  (a_sh[NIBBLE_W-1:0]),
        .y  (b_sh[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (nib_s),
        .co (nib_c)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand and result registers are plain flops, not a
            // RAM, so they are cleared here along with the control state.
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state <= RUN;
                a_q   <= a;
                b_q   <= b;
                carry <= cin;
                cnt   <= '0;
                res_q <= '0;
                busy  <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        res_q <= res_next;
                        carry <= nib_c;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            sum   <= res_next;
                            cout  <= nib_c;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed bench for serial_nibble_adder: a 4-nibble instance for the main
// scenarios and a 1-nibble instance for the minimum-width case.
module tb_serial_nibble_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    logic        start1 = 1'b0;
    logic [3:0]  a1 = '0;
    logic [3:0]  b1 = '0;
    logic        cin1 = 1'b0;
    logic        busy1;
    logic        done1;
    logic [3:0]  sum1;
    logic        cout1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_nibble_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_nibble_adder #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL reset_n1_ctl got busy=%b done=%b exp 0/0", busy1, done1); end
        checks++; if (sum1 !== 4'h0 || cout1 !== 1'b0) begin failures++; $display("FAIL reset_n1_data got sum=%h cout=%b exp 0/0", sum1, cout1); end
        #3 rst_n = 1'b1;
        tick();
    endtask

    // One add on the 4-nibble DUT: checks latency, busy length, result and
    // that sum stays put until the completion edge.
    task automatic run_add(input logic [15:0] ta, input logic [15:0] tb_op, input logic tc,
                           input logic [15:0] exp_sum, input logic exp_cout, input string name);
        int cycles;
        int busy_cycles;
        logic [15:0] old_sum;
        logic        sum_moved;
        old_sum   = sum;
        sum_moved = 1'b0;
        a = ta; b = tb_op; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        busy_cycles = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cycles++;
            if (sum !== old_sum) sum_moved = 1'b1;
            tick();
            cycles++;
        end
        checks++; if (cycles != 4) begin failures++; $display("FAIL %s_latency got=%0d exp=4", name, cycles); end
        checks++; if (busy_cycles != 4) begin failures++; $display("FAIL %s_busy_len got=%0d exp=4", name, busy_cycles); end
        checks++; if (sum_moved) begin failures++; $display("FAIL %s_sum_stable got=moved exp=held %h", name, old_sum); end
        checks++; if (sum !== exp_sum) begin failures++; $display("FAIL %s_sum got=%h exp=%h", name, sum, exp_sum); end
        checks++; if (cout !== exp_cout) begin failures++; $display("FAIL %s_cout got=%b exp=%b", name, cout, exp_cout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_at_done got=%b exp=0", name, busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_pulse got=%b exp=0", name, done); end
    endtask

    task automatic test_basic_adds;
        run_add(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "carry_one_nibble");
        run_add(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple_all");
        run_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "top_overflow");
    endtask

    task automatic test_ignore_start_mid_run;
        int pulses;
        logic [15:0] got;
        logic        got_c;
        pulses = 0;
        got = 'x;
        got_c = 1'bx;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        tick();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) begin
                pulses++;
                got = sum;
                got_c = cout;
            end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL midrun_pulses got=%0d exp=1", pulses); end
        checks++; if (got !== 16'h2345) begin failures++; $display("FAIL midrun_sum got=%h exp=2345", got); end
        checks++; if (got_c !== 1'b0) begin failures++; $display("FAIL midrun_cout got=%b exp=0", got_c); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int first_at;
        int pulses;
        logic rearmed;
        cyc = 0; first_at = -1; pulses = 0; rearmed = 1'b0;
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        tick();
        while (pulses < 2 && cyc < 30) begin
            tick();
            cyc++;
            if (rearmed) begin
                rearmed = 1'b0;
                start = 1'b0;
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_reaccept_busy got=%b exp=1", busy); end
            end
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    first_at = cyc;
                    checks++; if (sum !== 16'h0003 || cout !== 1'b0) begin failures++; $display("FAIL b2b_first got=%b_%h exp=0_0003", cout, sum); end
                    a = 16'hF000; b = 16'h1001; cin = 1'b0;
                    rearmed = 1'b1;
                end else begin
                    checks++; if (cyc - first_at != 5) begin failures++; $display("FAIL b2b_spacing got=%0d exp=5", cyc - first_at); end
                    checks++; if (sum !== 16'h0001 || cout !== 1'b1) begin failures++; $display("FAIL b2b_second got=%b_%h exp=1_0001", cout, sum); end
                end
            end
        end
        start = 1'b0;
        checks++; if (pulses != 2) begin failures++; $display("FAIL b2b_pulse_count got=%0d exp=2", pulses); end
        tick();
        tick();
    endtask

    task automatic test_async_reset;
        int pulses;
        pulses = 0;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_rst_ctl got busy=%b done=%b exp 0/0", busy, done); end
        checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin failures++; $display("FAIL async_rst_data got=%b_%h exp=0_0000", cout, sum); end
        #20 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL async_rst_no_done got=%0d exp=0", pulses); end
        run_add(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, "after_reset");
    endtask

    task automatic test_single_nibble;
        a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin failures++; $display("FAIL n1_accept got busy=%b done=%b exp 1/0", busy1, done1); end
        tick();
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin failures++; $display("FAIL n1_done got done=%b busy=%b exp 1/0", done1, busy1); end
        checks++; if (sum1 !== 4'h1 || cout1 !== 1'b1) begin failures++; $display("FAIL n1_result got=%b_%h exp=1_1", cout1, sum1); end
        tick();
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL n1_done_pulse got=%b exp=0", done1); end
    endtask

    initial begin
        test_reset();
        test_basic_adds();
        test_ignore_start_mid_run();
        test_back_to_back();
        test_async_reset();
        test_single_nibble();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
